wb_stage: RTL and testbench

WB_STAGE -- requirements
Module: wb_stage

---
 rtl/wb_stage.sv | 165 ++++++++++++++++
 tb/tb_wb_stage.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage.sv
// Writeback stage: non-loads write one cycle after accept; loads wait for mem_rvalid, extend, then write.
// in_ready drops while a load is outstanding or on flush. Forwarding outputs are built only with WB_FWD_EN.
module wb_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_wreg,
  input  logic [4:0]  in_wd,
  input  logic [31:0] in_wdata,
  input  logic        in_is_load,
  input  logic [2:0]  in_load_type,
  input  logic [1:0]  in_addr_lo,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  input  logic        flush,
  output logic        we,
  output logic [4:0]  waddr,
  output logic [31:0] wdata,
  output logic        fwd_valid,
  output logic        fwd_pending,
  output logic [4:0]  fwd_addr,
  output logic [31:0] retired_cnt
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_LOAD = 2'd1,
    WRITE     = 2'd2
  } state_t;

  localparam logic [2:0] LT_LB  = 3'd1;
  localparam logic [2:0] LT_LBU = 3'd2;
  localparam logic [2:0] LT_LH  = 3'd3;
  localparam logic [2:0] LT_LHU = 3'd4;

  // Unlisted load types fall back to a full word, as does LW itself.
  function automatic logic [31:0] load_extend(input logic [2:0]  lt,
                                              input logic [1:0]  lo,
                                              input logic [31:0] rd);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (lo)
      2'd0:    b = rd[7:0];
      2'd1:    b = rd[15:8];
      2'd2:    b = rd[23:16];
      default: b = rd[31:24];
    endcase
    h = lo[1] ? rd[31:16] : rd[15:0];
    case (lt)
      LT_LB:   r = {{24{b[7]}}, b};
      LT_LBU:  r = {24'd0, b};
      LT_LH:   r = {{16{h[15]}}, h};
      LT_LHU:  r = {16'd0, h};
      default: r = rd;
    endcase
    return r;
  endfunction

  state_t      state;
  state_t      state_nxt;
  logic        wreg_q;
  logic [4:0]  wd_q;
  logic [31:0] res_q;
  logic [2:0]  lt_q;
  logic [1:0]  lo_q;
  logic        accept;
  logic        load_done;
  logic        write_cycle;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    in_ready    = 1'b0;
    accept      = 1'b0;
    load_done   = 1'b0;
    write_cycle = 1'b0;
    case (state)
      IDLE, WRITE: in_ready = !flush;
      default:     in_ready = 1'b0;
    endcase
    accept      = in_valid && in_ready;
    load_done   = (state == WAIT_LOAD) && mem_rvalid && !flush;
    write_cycle = (state == WRITE) && !flush;

    if (flush) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE, WRITE: begin
          if (accept) begin
            state_nxt = in_is_load ? WAIT_LOAD : WRITE;
          end else begin
            state_nxt = IDLE;
          end
        end
        WAIT_LOAD: begin
          if (mem_rvalid) begin
            state_nxt = WRITE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Accept and load completion are exclusive, so res_q has a single writer per cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      wreg_q      <= 1'b0;
      wd_q        <= 5'd0;
      res_q       <= 32'd0;
      lt_q        <= 3'd0;
      lo_q        <= 2'd0;
      retired_cnt <= 32'd0;
    end else begin
      if (accept) begin
        wreg_q <= in_wreg;
        wd_q   <= in_wd;
        res_q  <= in_wdata;
        lt_q   <= in_load_type;
        lo_q   <= in_addr_lo;
      end else if (load_done) begin
        res_q <= load_extend(lt_q, lo_q, mem_rdata);
      end
      if (write_cycle) begin
        retired_cnt <= retired_cnt + 32'd1;
      end
    end
  end

  always_comb begin
    we    = write_cycle && !rst && wreg_q && (wd_q != 5'd0);
    waddr = we ? wd_q : 5'd0;
    wdata = we ? res_q : 32'd0;
  end

`ifdef WB_FWD_EN
  always_comb begin
    fwd_valid   = we;
    fwd_pending = (state == WAIT_LOAD) && !rst && wreg_q && (wd_q != 5'd0);
    fwd_addr    = 5'd0;
    if (!rst) begin
      if (state == WRITE) begin
        fwd_addr = waddr;
      end else if (state == WAIT_LOAD) begin
        fwd_addr = wd_q;
      end
    end
  end
`else
  assign fwd_valid   = 1'b0;
  assign fwd_pending = 1'b0;
  assign fwd_addr    = 5'd0;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: directed scenarios plus a randomized run against a transaction-level model.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_wreg;
  logic [4:0]  in_wd;
  logic [31:0] in_wdata;
  logic        in_is_load;
  logic [2:0]  in_load_type;
  logic [1:0]  in_addr_lo;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        flush;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        fwd_valid;
  logic        fwd_pending;
  logic [4:0]  fwd_addr;
  logic [31:0] retired_cnt;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] exp_cnt;
  logic        fwd_on;

  always #5 clk = ~clk;

  wb_stage dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_wreg(in_wreg), .in_wd(in_wd), .in_wdata(in_wdata),
    .in_is_load(in_is_load), .in_load_type(in_load_type), .in_addr_lo(in_addr_lo),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .flush(flush),
    .we(we), .waddr(waddr), .wdata(wdata),
    .fwd_valid(fwd_valid), .fwd_pending(fwd_pending), .fwd_addr(fwd_addr),
    .retired_cnt(retired_cnt)
  );

  // Load result from arithmetic on the shifted word rather than bit selects.
  function automatic logic [31:0] ref_extend(input int lt, input int lo, input logic [31:0] rd);
    logic [31:0] v;
    if (lt == 1 || lt == 2) begin
      v = (rd >> (8 * lo)) & 32'hFF;
      if (lt == 1 && v >= 32'd128) v = v + 32'hFFFF_FF00;
    end else if (lt == 3 || lt == 4) begin
      v = (rd >> (16 * (lo / 2))) & 32'hFFFF;
      if (lt == 3 && v >= 32'd32768) v = v + 32'hFFFF_0000;
    end else begin
      v = rd;
    end
    return v;
  endfunction

  task automatic drive_idle();
    in_valid = 0; in_wreg = 0; in_wd = 0; in_wdata = 0; in_is_load = 0;
    in_load_type = 0; in_addr_lo = 0; mem_rvalid = 0; mem_rdata = 0; flush = 0;
  endtask

  task automatic drive_op(input logic wreg, input logic [4:0] wd, input logic [31:0] dat,
                          input logic ld, input logic [2:0] lt, input logic [1:0] lo);
    drive_idle();
    in_valid = 1; in_wreg = wreg; in_wd = wd; in_wdata = dat;
    in_is_load = ld; in_load_type = lt; in_addr_lo = lo;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1;
    drive_op(1, 5'd3, 32'hDEAD_BEEF, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    drive_idle();
    exp_cnt = 0;
    #1;
    n_cmp++;
    if ({we, waddr, wdata, fwd_valid, fwd_pending, fwd_addr, retired_cnt} !== 77'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: got we=%0b waddr=%0d wdata=%h fv=%0b fp=%0b fa=%0d cnt=%0d, want all 0",
               we, waddr, wdata, fwd_valid, fwd_pending, fwd_addr, retired_cnt);
    end
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_ready: got %0b want 1", in_ready);
    end
  endtask

  task automatic test_nonload();
    @(negedge clk);
    drive_op(1, 5'd5, 32'h1234_5678, 0, 0, 0);
    @(negedge clk);
    drive_idle();
    #1;
    n_cmp++;
    if ({we, waddr, wdata} !== {1'b1, 5'd5, 32'h1234_5678}) begin
      n_bad++;
      $display("FAIL nonload_write: got we=%0b waddr=%0d wdata=%h want 1 5 12345678", we, waddr, wdata);
    end
    n_cmp++;
    if (fwd_valid !== fwd_on || fwd_addr !== (fwd_on ? 5'd5 : 5'd0)) begin
      n_bad++;
      $display("FAIL nonload_fwd: got fv=%0b fa=%0d want %0b %0d", fwd_valid, fwd_addr, fwd_on, fwd_on ? 5 : 0);
    end
    exp_cnt = exp_cnt + 1;
    @(negedge clk);
    #1;
    n_cmp++;
    if ({we, waddr, wdata} !== 38'd0 || retired_cnt !== exp_cnt) begin
      n_bad++;
      $display("FAIL nonload_one_cycle: got we=%0b cnt=%0d want 0 %0d", we, retired_cnt, exp_cnt);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i < 3) drive_op(1, 5'(i + 1), 32'hA000_0000 + 32'(i), 0, 0, 0);
      else drive_idle();
      #1;
      n_cmp++;
      if (in_ready !== 1'b1) begin
        n_bad++;
        $display("FAIL b2b_ready cycle %0d: got %0b want 1", i, in_ready);
      end
      if (i > 0) begin
        n_cmp++;
        if ({we, waddr, wdata} !== {1'b1, 5'(i), 32'hA000_0000 + 32'(i - 1)}) begin
          n_bad++;
          $display("FAIL b2b_write cycle %0d: got we=%0b waddr=%0d wdata=%h want 1 %0d %h",
                   i, we, waddr, wdata, i, 32'hA000_0000 + 32'(i - 1));
        end
      end
    end
    exp_cnt = exp_cnt + 3;
    @(negedge clk);
    #1;
    n_cmp++;
    if (we !== 1'b0 || retired_cnt !== exp_cnt) begin
      n_bad++;
      $display("FAIL b2b_end: got we=%0b cnt=%0d want 0 %0d", we, retired_cnt, exp_cnt);
    end
  endtask

  task automatic run_load(input string nm, input logic [4:0] wd, input logic [2:0] lt,
                          input logic [1:0] lo, input logic [31:0] rd, input logic [31:0] want);
    @(negedge clk);
    drive_op(1, wd, 32'h5555_5555, 1, lt, lo);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      drive_idle();
      #1;
      n_cmp++;
      if (in_ready !== 1'b0 || we !== 1'b0) begin
        n_bad++;
        $display("FAIL %s_wait: got in_ready=%0b we=%0b want 0 0", nm, in_ready, we);
      end
      n_cmp++;
      if (fwd_pending !== fwd_on || fwd_addr !== (fwd_on ? wd : 5'd0)) begin
        n_bad++;
        $display("FAIL %s_pending: got fp=%0b fa=%0d want %0b", nm, fwd_pending, fwd_addr, fwd_on);
      end
    end
    @(negedge clk);
    mem_rvalid = 1; mem_rdata = rd;
    @(negedge clk);
    drive_idle();
    #1;
    n_cmp++;
    if ({we, waddr, wdata} !== {1'b1, wd, want}) begin
      n_bad++;
      $display("FAIL %s_write: got we=%0b waddr=%0d wdata=%h want 1 %0d %h", nm, we, waddr, wdata, wd, want);
    end
    exp_cnt = exp_cnt + 1;
    @(negedge clk);
  endtask

  task automatic test_load();
    run_load("lb", 5'd7, 3'd1, 2'd2, 32'h0080_0000, 32'hFFFF_FF80);
    run_load("lhu", 5'd9, 3'd4, 2'd2, 32'h8001_ABCD, 32'h0000_8001);
  endtask

  task automatic test_flush_wait();
    @(negedge clk);
    drive_op(1, 5'd11, 32'h0, 1, 0, 0);
    @(negedge clk);
    drive_op(1, 5'd12, 32'h77, 0, 0, 0);
    flush = 1;
    #1;
    n_cmp++;
    if (in_ready !== 1'b0 || we !== 1'b0) begin
      n_bad++;
      $display("FAIL flush_cycle: got in_ready=%0b we=%0b want 0 0", in_ready, we);
    end
    @(negedge clk);
    drive_idle();
    mem_rvalid = 1; mem_rdata = 32'hCAFE_F00D;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL flush_idle: got in_ready=%0b want 1", in_ready);
    end
    @(negedge clk);
    drive_idle();
    #1;
    n_cmp++;
    if (we !== 1'b0 || retired_cnt !== exp_cnt) begin
      n_bad++;
      $display("FAIL flush_nowrite: got we=%0b cnt=%0d want 0 %0d", we, retired_cnt, exp_cnt);
    end
  endtask

  task automatic test_r0();
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      if (k == 0) drive_op(1, 5'd0, 32'hFFFF_0000, 0, 0, 0);
      else drive_op(0, 5'd4, 32'hFFFF_0000, 0, 0, 0);
      @(negedge clk);
      drive_idle();
      #1;
      n_cmp++;
      if ({we, waddr, wdata} !== 38'd0) begin
        n_bad++;
        $display("FAIL r0_nowrite case %0d: got we=%0b waddr=%0d wdata=%h want 0 0 0", k, we, waddr, wdata);
      end
      exp_cnt = exp_cnt + 1;
      @(negedge clk);
      #1;
      n_cmp++;
      if (retired_cnt !== exp_cnt) begin
        n_bad++;
        $display("FAIL r0_count case %0d: got %0d want %0d", k, retired_cnt, exp_cnt);
      end
    end
  endtask

  task automatic test_reset_mid_load();
    @(negedge clk);
    drive_op(1, 5'd20, 32'h0, 1, 0, 0);
    @(negedge clk);
    drive_idle();
    rst = 1;
    @(negedge clk);
    rst = 0;
    exp_cnt = 0;
    mem_rvalid = 1; mem_rdata = 32'h1111_2222;
    #1;
    n_cmp++;
    if ({we, waddr, wdata, fwd_valid, fwd_pending, fwd_addr, retired_cnt} !== 77'd0 || in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL rst_midload: got we=%0b fp=%0b fa=%0d cnt=%0d rdy=%0b want 0 0 0 0 1",
               we, fwd_pending, fwd_addr, retired_cnt, in_ready);
    end
    @(negedge clk);
    drive_idle();
    #1;
    n_cmp++;
    if (we !== 1'b0 || retired_cnt !== 32'd0) begin
      n_bad++;
      $display("FAIL rst_late_rvalid: got we=%0b cnt=%0d want 0 0", we, retired_cnt);
    end
  endtask

  task automatic test_random();
    logic        m_load;
    logic        l_wreg;
    logic [4:0]  l_wd;
    int          l_lt;
    int          l_lo;
    logic        m_wr;
    logic        m_wen;
    logic [4:0]  m_addr;
    logic [31:0] m_data;
    logic        n_wr;
    logic        e_we;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    @(negedge clk);
    drive_idle();
    rst = 1;
    @(negedge clk);
    rst = 0;
    exp_cnt = 0;
    m_load = 0; m_wr = 0; m_wen = 0; m_addr = 0; m_data = 0;
    l_wreg = 0; l_wd = 0; l_lt = 0; l_lo = 0;
    for (int c = 0; c < 600; c++) begin
      if (c > 0) @(negedge clk);
      in_valid     = ($urandom_range(0, 9) < 6);
      in_wreg      = ($urandom_range(0, 7) != 0);
      in_wd        = 5'($urandom_range(0, 31));
      in_wdata     = $urandom;
      in_is_load   = 1'($urandom_range(0, 1));
      in_load_type = 3'($urandom_range(0, 7));
      in_addr_lo   = 2'($urandom_range(0, 3));
      mem_rvalid   = ($urandom_range(0, 2) == 0);
      mem_rdata    = $urandom;
      flush        = ($urandom_range(0, 19) == 0);
      #1;
      e_we   = m_wr && m_wen && !flush;
      e_addr = e_we ? m_addr : 5'd0;
      e_data = e_we ? m_data : 32'd0;
      n_cmp++;
      if (in_ready !== (!m_load && !flush)) begin
        n_bad++;
        $display("FAIL rnd_ready cycle %0d: got %0b want %0b", c, in_ready, !m_load && !flush);
      end
      n_cmp++;
      if ({we, waddr, wdata} !== {e_we, e_addr, e_data}) begin
        n_bad++;
        $display("FAIL rnd_write cycle %0d: got %0b %0d %h want %0b %0d %h", c, we, waddr, wdata, e_we, e_addr, e_data);
      end
      n_cmp++;
      if (retired_cnt !== exp_cnt) begin
        n_bad++;
        $display("FAIL rnd_count cycle %0d: got %0d want %0d", c, retired_cnt, exp_cnt);
      end
      n_cmp++;
      if (fwd_valid !== (fwd_on && e_we) ||
          fwd_pending !== (fwd_on && m_load && l_wreg && l_wd != 0) ||
          fwd_addr !== (!fwd_on ? 5'd0 : (m_load ? l_wd : e_addr))) begin
        n_bad++;
        $display("FAIL rnd_fwd cycle %0d: got fv=%0b fp=%0b fa=%0d", c, fwd_valid, fwd_pending, fwd_addr);
      end
      if (flush) begin
        m_load = 0;
        m_wr   = 0;
      end else begin
        if (m_wr) exp_cnt = exp_cnt + 1;
        n_wr = 0;
        if (m_load && mem_rvalid) begin
          n_wr = 1; m_wen = l_wreg && (l_wd != 0); m_addr = l_wd;
          m_data = ref_extend(l_lt, l_lo, mem_rdata);
          m_load = 0;
        end else if (!m_load && in_valid) begin
          if (in_is_load) begin
            m_load = 1; l_wreg = in_wreg; l_wd = in_wd;
            l_lt = int'(in_load_type); l_lo = int'(in_addr_lo);
          end else begin
            n_wr = 1; m_wen = in_wreg && (in_wd != 0); m_addr = in_wd; m_data = in_wdata;
          end
        end
        m_wr = n_wr;
      end
    end
    @(negedge clk);
    drive_idle();
  endtask

  initial begin
`ifdef WB_FWD_EN
    fwd_on = 1'b1;
`else
    fwd_on = 1'b0;
`endif
    rst = 1;
    exp_cnt = 0;
    drive_idle();
    test_reset();
    test_nonload();
    test_back_to_back();
    test_load();
    test_flush_wait();
    test_r0();
    test_reset_mid_load();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

endmodule
